// File: rtl/sm2201_pkg.sv
// Shared encodings and default constants for the ISA read byte sequencer.
package sm2201_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    LOADED     = 3'd1,
    LOW_DRIVE  = 3'd2,
    WAIT_HIGH  = 3'd3,
    HIGH_DRIVE = 3'd4
  } seq_state_t;

  localparam int SYNC_STAGES_DEF    = 2;
  localparam int TIMEOUT_CYCLES_DEF = 1000;

endpackage

// File: rtl/isa_strobe_sync.sv
// Brings the asynchronous ior strobe into the clk domain and emits
// one-cycle rise/fall pulses from a registered copy of the synchronised level.
module isa_strobe_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic ior,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync <= '0;
      prev <= 1'b0;
    end else begin
      sync[0] <= ior;
      for (int i = 1; i < SYNC_STAGES; i++) sync[i] <= sync[i-1];
      prev <= sync[SYNC_STAGES-1];
    end
  end

  assign rise = sync[SYNC_STAGES-1] & ~prev;
  assign fall = ~sync[SYNC_STAGES-1] & prev;

endmodule

// File: rtl/isa_read_byte_sequencer.sv
// Presents a 16-bit CAMAC word to the ISA bus as two byte reads via an LS257.
// Optional high-byte read timeout: define ISA_SEQ_TIMEOUT_EN.
module isa_read_byte_sequencer
  import sm2201_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int SYNC_STAGES    = SYNC_STAGES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ior,
  input  logic        address_match,
  input  logic [15:0] camac_data,
  input  logic        camac_data_valid,
  output logic [7:0]  mux_a,
  output logic [7:0]  mux_b,
  output logic        mux_select,
  output logic        mux_out_control,
  output logic        busy,
  output logic        overrun,
  output logic        timeout
);

  if (TIMEOUT_CYCLES < 2 || SYNC_STAGES < 1) begin : g_bad_param
    $error("isa_read_byte_sequencer: TIMEOUT_CYCLES >= 2 and SYNC_STAGES >= 1 required");
  end

  seq_state_t state, state_nxt;
  logic       rise, fall;
  logic       sel_nxt, oc_nxt, busy_nxt, load;
  logic       timeout_hit;

  isa_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .reset (reset),
    .ior   (ior),
    .rise  (rise),
    .fall  (fall)
  );

`ifdef ISA_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  logic [TW-1:0] tcnt;

  assign timeout_hit = (state == WAIT_HIGH) && (tcnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tcnt    <= '0;
      timeout <= 1'b0;
    end else begin
      tcnt <= (state == WAIT_HIGH && !timeout_hit) ? tcnt + 1'b1 : '0;
      if (timeout_hit) timeout <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign timeout     = 1'b0;
`endif

  // select moves only on cycles where the bus is already released: it is
  // raised while parked in WAIT_HIGH and dropped while parked in IDLE.
  always_comb begin
    state_nxt = state;
    sel_nxt   = mux_select;
    oc_nxt    = mux_out_control;
    busy_nxt  = busy;
    load      = 1'b0;
    case (state)
      IDLE: begin
        sel_nxt  = 1'b0;
        oc_nxt   = 1'b1;
        busy_nxt = 1'b0;
        if (camac_data_valid) begin
          load      = 1'b1;
          busy_nxt  = 1'b1;
          state_nxt = LOADED;
        end
      end
      LOADED: begin
        sel_nxt = 1'b0;
        if (rise && address_match) begin
          oc_nxt    = 1'b0;
          state_nxt = LOW_DRIVE;
        end
      end
      LOW_DRIVE: begin
        if (fall) begin
          oc_nxt    = 1'b1;
          state_nxt = WAIT_HIGH;
        end
      end
      WAIT_HIGH: begin
        sel_nxt = 1'b1;
        if (timeout_hit) begin
          busy_nxt  = 1'b0;
          state_nxt = IDLE;
        end else if (rise && address_match) begin
          oc_nxt    = 1'b0;
          state_nxt = HIGH_DRIVE;
        end
      end
      HIGH_DRIVE: begin
        if (fall) begin
          oc_nxt    = 1'b1;
          busy_nxt  = 1'b0;
          state_nxt = IDLE;
        end
      end
      default: begin
        oc_nxt    = 1'b1;
        busy_nxt  = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      mux_a           <= '0;
      mux_b           <= '0;
      mux_select      <= 1'b0;
      mux_out_control <= 1'b1;
      busy            <= 1'b0;
      overrun         <= 1'b0;
    end else begin
      state           <= state_nxt;
      mux_select      <= sel_nxt;
      mux_out_control <= oc_nxt;
      busy            <= busy_nxt;
      if (load) begin
        mux_a <= camac_data[7:0];
        mux_b <= camac_data[15:8];
      end
      if (camac_data_valid && state != IDLE) overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_isa_read_byte_sequencer.sv
// Self-checking bench: table of words read back through two ior strobes,
// scoreboard of expected bus bytes compared whenever the bus starts driving.
module tb_isa_read_byte_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ior = 1'b0;
  logic        address_match = 1'b0;
  logic [15:0] camac_data = '0;
  logic        camac_data_valid = 1'b0;
  logic [7:0]  mux_a, mux_b;
  logic        mux_select, mux_out_control, busy, overrun, timeout;

  isa_read_byte_sequencer #(.TIMEOUT_CYCLES(16), .SYNC_STAGES(2)) dut (
    .clk              (clk),
    .reset            (reset),
    .ior              (ior),
    .address_match    (address_match),
    .camac_data       (camac_data),
    .camac_data_valid (camac_data_valid),
    .mux_a            (mux_a),
    .mux_b            (mux_b),
    .mux_select       (mux_select),
    .mux_out_control  (mux_out_control),
    .busy             (busy),
    .overrun          (overrun),
    .timeout          (timeout)
  );

  always #10 clk = ~clk;

  typedef struct {
    logic [15:0] word;
    logic [7:0]  lo;
    logic [7:0]  hi;
  } vec_t;

  typedef struct {
    string      name;
    logic       sel;
    logic [7:0] bus;
  } exp_t;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb[$];
  vec_t vecs[5];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Whenever the LS257 starts driving, the byte it presents must be the next expected one.
  logic oc_prev = 1'b1;
  always @(negedge clk) begin
    if (oc_prev === 1'b1 && mux_out_control === 1'b0) begin
      if (sb.size() == 0) begin
        check("unexpected_drive", 32'(mux_out_control), 32'(1'b1));
      end else begin
        exp_t e;
        e = sb.pop_front();
        check({e.name, "_sel"}, 32'(mux_select), 32'(e.sel));
        check({e.name, "_bus"}, 32'(mux_select ? mux_b : mux_a), 32'(e.bus));
      end
    end
    oc_prev = mux_out_control;
  end

  task automatic load(input logic [15:0] w);
    @(posedge clk); #2;
    camac_data = w;
    camac_data_valid = 1'b1;
    @(posedge clk); #2;
    camac_data_valid = 1'b0;
  endtask

  task automatic ior_pulse(input logic am, input bit push, input string nm,
                           input logic sel, input logic [7:0] b);
    exp_t e;
    @(posedge clk); #3;
    address_match = am;
    ior = 1'b1;
    if (push) begin
      e.name = nm; e.sel = sel; e.bus = b;
      sb.push_back(e);
    end
    #200 ior = 1'b0;
    #200;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{16'h24B1, 8'hB1, 8'h24};
    vecs[1] = '{16'h0000, 8'h00, 8'h00};
    vecs[2] = '{16'hFFFF, 8'hFF, 8'hFF};
    vecs[3] = '{16'h8001, 8'h01, 8'h80};
    vecs[4] = '{16'h5AA5, 8'hA5, 8'h5A};

    // reset values
    #55;
    check("rst_mux_a", 32'(mux_a), 32'h0);
    check("rst_mux_b", 32'(mux_b), 32'h0);
    check("rst_sel", 32'(mux_select), 32'h0);
    check("rst_oc", 32'(mux_out_control), 32'h1);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_overrun", 32'(overrun), 32'h0);
    check("rst_timeout", 32'(timeout), 32'h0);
    @(negedge clk) reset = 1'b0;

    // table: load, read low, read high
    for (int i = 0; i < 5; i++) begin
      load(vecs[i].word);
      check($sformatf("v%0d_mux_a", i), 32'(mux_a), 32'(vecs[i].lo));
      check($sformatf("v%0d_mux_b", i), 32'(mux_b), 32'(vecs[i].hi));
      check($sformatf("v%0d_busy", i), 32'(busy), 32'h1);
      check($sformatf("v%0d_oc_idle", i), 32'(mux_out_control), 32'h1);
      check($sformatf("v%0d_sel_idle", i), 32'(mux_select), 32'h0);
      ior_pulse(1'b1, 1'b1, $sformatf("v%0d_lo", i), 1'b0, vecs[i].lo);
      check($sformatf("v%0d_oc_between", i), 32'(mux_out_control), 32'h1);
      check($sformatf("v%0d_busy_between", i), 32'(busy), 32'h1);
      ior_pulse(1'b1, 1'b1, $sformatf("v%0d_hi", i), 1'b1, vecs[i].hi);
      check($sformatf("v%0d_busy_done", i), 32'(busy), 32'h0);
      check($sformatf("v%0d_oc_done", i), 32'(mux_out_control), 32'h1);
      check($sformatf("v%0d_sel_done", i), 32'(mux_select), 32'h0);
    end

    // overrun: second word while busy is discarded, flag sticks
    load(16'h24B1);
    check("ovr_before", 32'(overrun), 32'h0);
    load(16'h1234);
    check("ovr_set", 32'(overrun), 32'h1);
    check("ovr_mux_a", 32'(mux_a), 32'hB1);
    check("ovr_mux_b", 32'(mux_b), 32'h24);
    ior_pulse(1'b1, 1'b1, "ovr_lo", 1'b0, 8'hB1);
    ior_pulse(1'b1, 1'b1, "ovr_hi", 1'b1, 8'h24);
    check("ovr_sticky", 32'(overrun), 32'h1);

    // non-addressed strobe ignored in LOADED
    load(16'h3C5A);
    ior_pulse(1'b0, 1'b0, "", 1'b0, 8'h00);
    check("na_oc", 32'(mux_out_control), 32'h1);
    check("na_busy", 32'(busy), 32'h1);
    ior_pulse(1'b1, 1'b1, "na_lo", 1'b0, 8'h5A);
    ior_pulse(1'b1, 1'b1, "na_hi", 1'b1, 8'h3C);

    // latency: bus drives on the 3rd clk edge after ior rises
    load(16'h7788);
    begin
      exp_t e;
      int   n;
      @(posedge clk); #2;
      address_match = 1'b1;
      ior = 1'b1;
      e.name = "lat_lo"; e.sel = 1'b0; e.bus = 8'h88;
      sb.push_back(e);
      n = 0;
      for (int k = 0; k < 10; k++) begin
        @(posedge clk); #1;
        n++;
        if (mux_out_control === 1'b0) break;
      end
      check("lat_edges", 32'(n), 32'd3);
      #150 ior = 1'b0;
      #200;
    end
    ior_pulse(1'b1, 1'b1, "lat_hi", 1'b1, 8'h77);

    // load and ior rise in the same cycle: load wins, the rise is dropped
    @(posedge clk); #2;
    address_match = 1'b1;
    ior = 1'b1;
    @(posedge clk);
    @(posedge clk); #2;
    camac_data = 16'h6E9F;
    camac_data_valid = 1'b1;
    @(posedge clk); #2;
    camac_data_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("coll_oc", 32'(mux_out_control), 32'h1);
    check("coll_busy", 32'(busy), 32'h1);
    check("coll_mux_a", 32'(mux_a), 32'h9F);
    ior = 1'b0;
    #200;
    ior_pulse(1'b1, 1'b1, "coll_lo", 1'b0, 8'h9F);
    ior_pulse(1'b1, 1'b1, "coll_hi", 1'b1, 8'h6E);

    // only the low byte is read
    load(16'hC3D2);
    ior_pulse(1'b1, 1'b1, "to_lo", 1'b0, 8'hD2);
    repeat (40) @(posedge clk);
    #1;
`ifdef ISA_SEQ_TIMEOUT_EN
    check("to_busy", 32'(busy), 32'h0);
    check("to_flag", 32'(timeout), 32'h1);
    check("to_oc", 32'(mux_out_control), 32'h1);
`else
    check("noto_busy", 32'(busy), 32'h1);
    check("noto_flag", 32'(timeout), 32'h0);
    ior_pulse(1'b1, 1'b1, "noto_hi", 1'b1, 8'hC3);
`endif

    // reset during HIGH_DRIVE releases the bus immediately
    load(16'hABCD);
    ior_pulse(1'b1, 1'b1, "rd_lo", 1'b0, 8'hCD);
    begin
      exp_t e;
      bit   seen;
      @(posedge clk); #3;
      address_match = 1'b1;
      ior = 1'b1;
      e.name = "rd_hi"; e.sel = 1'b1; e.bus = 8'hAB;
      sb.push_back(e);
      seen = 0;
      for (int k = 0; k < 20 && !seen; k++) begin
        @(posedge clk); #1;
        if (mux_out_control === 1'b0) seen = 1;
      end
      check("rd_reached_drive", 32'(seen), 32'h1);
      @(negedge clk); #4;
      reset = 1'b1;
      #1;
      check("rd_oc", 32'(mux_out_control), 32'h1);
      check("rd_sel", 32'(mux_select), 32'h0);
      check("rd_busy", 32'(busy), 32'h0);
      check("rd_mux_a", 32'(mux_a), 32'h0);
      check("rd_mux_b", 32'(mux_b), 32'h0);
      check("rd_overrun", 32'(overrun), 32'h0);
      check("rd_timeout", 32'(timeout), 32'h0);
      ior = 1'b0;
      #100;
      @(negedge clk) reset = 1'b0;
      #100;
    end

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
